// File: rtl/switch_pkg.sv
// Shared types, default widths and the address-to-port routing helper for the N-port switch.
package switch_pkg;

  typedef enum logic {
    BACKPRESSURE = 1'b0,
    DROP         = 1'b1
  } drop_mode_e;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefNumPorts  = 4;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned DefCntWidth  = 16;
  localparam int unsigned MaxAddrWidth = 32;

  // Top port_bits bits of an addr_width-wide address, returned right-aligned.
  function automatic logic [MaxAddrWidth-1:0] port_sel(input logic [MaxAddrWidth-1:0] addr,
                                                       input int unsigned addr_width,
                                                       input int unsigned port_bits);
    logic [MaxAddrWidth-1:0] mask;
    mask = (MaxAddrWidth'(1) << port_bits) - MaxAddrWidth'(1);
    return (addr >> (addr_width - port_bits)) & mask;
  endfunction

endpackage

// File: rtl/switch_if.sv
// Input beat handshake plus per-port output handshakes and drop counter of the N-port switch.
interface switch_if
  import switch_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = DefNumPorts,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
);
  logic                                  vld;
  logic                                  rdy;
  logic [ADDR_WIDTH-1:0]                 addr;
  logic [DATA_WIDTH-1:0]                 data;
  logic [NUM_PORTS-1:0]                  out_vld;
  logic [NUM_PORTS-1:0]                  out_rdy;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  out_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  out_data;
  logic [CNT_WIDTH-1:0]                  drop_cnt;

  modport master (
    output vld, addr, data, out_rdy,
    input  rdy, out_vld, out_addr, out_data, drop_cnt
  );

  modport slave (
    input  vld, addr, data, out_rdy,
    output rdy, out_vld, out_addr, out_data, drop_cnt
  );

  modport switch_nport_mp (
    input  vld, addr, data, out_rdy,
    output rdy, out_vld, out_addr, out_data, drop_cnt
  );

endinterface

// File: rtl/switch_fifo.sv
// Per-port FIFO with wrap-bit pointers and a registered head-of-queue output (no fall-through).
module switch_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop, last;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign last    = ((wr_ptr_q - rd_ptr_q) == {{AW{1'b0}}, 1'b1});
  assign dout    = dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    // Keep dout_q equal to the entry that will be at the head after this edge.
    if (do_pop) begin
      if (!last) begin
        dout_d = mem_q[rd_ptr_d[AW-1:0]];
      end else if (do_push) begin
        dout_d = din;
      end
    end else if (do_push && empty) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/switch_nport.sv
// Routes each input beat to one of NUM_PORTS output FIFOs by its address MSBs; on a full FIFO it
// either backpressures the source or accepts and discards the beat, counting the drop.
module switch_nport
  import switch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned NUM_PORTS    = DefNumPorts,
  parameter int unsigned FIFO_DEPTH   = DefFifoDepth,
  parameter drop_mode_e  DROP_ON_FULL = BACKPRESSURE,
  parameter int unsigned CNT_WIDTH    = DefCntWidth
) (
  input  logic                   clk,
  input  logic                   rstn,
  switch_if.switch_nport_mp      bus
);

  localparam int unsigned PortBits = $clog2(NUM_PORTS);
  localparam int unsigned EntryW   = ADDR_WIDTH + DATA_WIDTH;

  logic [PortBits-1:0]                  sel;
  logic [NUM_PORTS-1:0]                 full, empty, push, pop;
  logic                                 xfer, drop;
  logic [CNT_WIDTH-1:0]                 drop_cnt_q, drop_cnt_d;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] head_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] head_data;

  assign sel  = PortBits'(port_sel(MaxAddrWidth'(bus.addr), ADDR_WIDTH, PortBits));
  // rdy depends only on the FIFO fill state, never on out_rdy.
  assign bus.rdy = (DROP_ON_FULL == DROP) ? 1'b1 : !full[sel];
  assign xfer = bus.vld && bus.rdy;
  assign drop = xfer && full[sel];
  assign pop  = ~empty & bus.out_rdy;

  always_comb begin
    push = '0;
    if (xfer && !full[sel]) begin
      push[sel] = 1'b1;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [EntryW-1:0] dout;

    switch_fifo #(
      .WIDTH (EntryW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[p]),
      .din   ({bus.addr, bus.data}),
      .full  (full[p]),
      .pop   (pop[p]),
      .dout  (dout),
      .empty (empty[p])
    );

    assign head_addr[p] = dout[EntryW-1 -: ADDR_WIDTH];
    assign head_data[p] = dout[DATA_WIDTH-1:0];
  end

  assign bus.out_vld  = ~empty;
  assign bus.out_addr = head_addr;
  assign bus.out_data = head_data;
  assign bus.drop_cnt = drop_cnt_q;

endmodule
